// File: rtl/dsp_pkg.sv
// Shared widths and saturation limits for the systolic-array MAC cell.
// Limits are returned in a wide vector; callers slice to their working width.
package dsp_pkg;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 32;
  localparam int OW_DEF  = 16;
  localparam int SHW_DEF = 5;
  localparam int LIMW    = 128;

  function automatic logic [LIMW-1:0] smax(input int w);
    return (LIMW'(1) << (w - 1)) - LIMW'(1);
  endfunction

  // Two's complement: -2^(w-1) is the bitwise inverse of 2^(w-1)-1.
  function automatic logic [LIMW-1:0] smin(input int w);
    return ~smax(w);
  endfunction

  function automatic logic [LIMW-1:0] umax(input int w);
    return (LIMW'(1) << w) - LIMW'(1);
  endfunction

endpackage

// File: rtl/dsp_round_sat.sv
// Combinational round/shift/clamp from IW to OW bits with a clamp flag.
// Used with shift=0 for the accumulator clamp and with the user shift at the output.
module dsp_round_sat
  import dsp_pkg::*;
#(
  parameter int IW  = 33,
  parameter int OW  = 16,
  parameter int SHW = 5
) (
  input  logic [IW-1:0]  i_val,
  input  logic [SHW-1:0] i_shift,
  input  logic           i_rnd,
  input  logic           i_uns,
  output logic [OW-1:0]  o_val,
  output logic           o_clamp
);

  // One guard bit so a rounding carry is clamped instead of wrapping.
  localparam int EW = IW + 1;
  localparam logic [LIMW-1:0] L_SMAX = smax(OW);
  localparam logic [LIMW-1:0] L_SMIN = smin(OW);
  localparam logic [LIMW-1:0] L_UMAX = umax(OW);

  logic [EW-1:0]        w_ext;
  logic [EW-1:0]        w_rnd_add;
  logic [EW-1:0]        w_sum;
  logic signed [EW-1:0] w_ashr;
  logic [EW-1:0]        w_shifted;
  logic [EW-1:0]        w_smax;
  logic [EW-1:0]        w_smin;
  logic [EW-1:0]        w_umax;

  assign w_smax    = L_SMAX[EW-1:0];
  assign w_smin    = L_SMIN[EW-1:0];
  assign w_umax    = L_UMAX[EW-1:0];
  assign w_ext     = {(i_uns ? 1'b0 : i_val[IW-1]), i_val};
  assign w_rnd_add = (i_rnd && (i_shift != '0)) ? (EW'(1) << (i_shift - 1'b1)) : '0;
  assign w_sum     = w_ext + w_rnd_add;
  assign w_ashr    = $signed(w_sum) >>> i_shift;
  assign w_shifted = i_uns ? (w_sum >> i_shift) : w_ashr;

  always_comb begin
    o_clamp = 1'b0;
    o_val   = w_shifted[OW-1:0];
    if (i_uns) begin
      if (w_shifted > w_umax) begin
        o_clamp = 1'b1;
        o_val   = w_umax[OW-1:0];
      end
    end else if ($signed(w_shifted) > $signed(w_smax)) begin
      o_clamp = 1'b1;
      o_val   = w_smax[OW-1:0];
    end else if ($signed(w_shifted) < $signed(w_smin)) begin
      o_clamp = 1'b1;
      o_val   = w_smin[OW-1:0];
    end
  end

endmodule

// File: rtl/dsp_mac_q.sv
// Systolic-array PE MAC: enable-driven A/B, product and accumulator registers,
// with a Q-format shift/round/saturate output stage published on drain.
module dsp_mac_q
  import dsp_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int OW  = OW_DEF,
  parameter int SHW = SHW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  a_value,
  input  logic [DW-1:0]  b_value,
  input  logic           aen,
  input  logic           ben,
  input  logic           men,
  input  logic           sen,
  input  logic           sreset,
  input  logic           uns,
  input  logic [SHW-1:0] shift,
  input  logic           rnd,
  output logic           sat_acc,
  output logic           sat,
  output logic [OW-1:0]  s_out,
  output logic           s_valid
);

  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [AW:0]    r_prod;
  logic [AW-1:0]  r_acc;
  logic           r_sat_acc;
  logic           r_sat;
  logic [OW-1:0]  r_s_out;
  logic           r_s_valid;

  logic signed [2*DW-1:0] w_prod_s;
  logic [2*DW-1:0]        w_prod_u;
  logic [AW:0]            w_prod_ext;
  logic [AW:0]            w_acc_ext;
  logic [AW:0]            w_sum;
  logic [AW-1:0]          w_acc_next;
  logic                   w_acc_clamp;
  logic [AW-1:0]          w_drain;
  logic [AW:0]            w_drain_ext;
  logic [OW-1:0]          w_out;
  logic                   w_out_clamp;

  assign w_prod_s   = $signed(r_a) * $signed(r_b);
  assign w_prod_u   = r_a * r_b;
  assign w_prod_ext = uns ? {{(AW+1-2*DW){1'b0}}, w_prod_u}
                          : {{(AW+1-2*DW){w_prod_s[2*DW-1]}}, w_prod_s};

  assign w_acc_ext  = {(uns ? 1'b0 : r_acc[AW-1]), r_acc};
  assign w_sum      = w_acc_ext + r_prod;

  dsp_round_sat #(.IW(AW+1), .OW(AW), .SHW(SHW)) u_acc_sat (
    .i_val   (w_sum),
    .i_shift ('0),
    .i_rnd   (1'b0),
    .i_uns   (uns),
    .o_val   (w_acc_next),
    .o_clamp (w_acc_clamp)
  );

  // A drain coinciding with sen publishes the freshly accumulated value.
  assign w_drain     = sen ? w_acc_next : r_acc;
  assign w_drain_ext = {(uns ? 1'b0 : w_drain[AW-1]), w_drain};

  dsp_round_sat #(.IW(AW+1), .OW(OW), .SHW(SHW)) u_out_sat (
    .i_val   (w_drain_ext),
    .i_shift (shift),
    .i_rnd   (rnd),
    .i_uns   (uns),
    .o_val   (w_out),
    .o_clamp (w_out_clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_prod    <= '0;
      r_acc     <= '0;
      r_sat_acc <= 1'b0;
      r_sat     <= 1'b0;
      r_s_out   <= '0;
      r_s_valid <= 1'b0;
    end else begin
      if (aen) r_a <= a_value;
      if (ben) r_b <= b_value;
      if (men) r_prod <= w_prod_ext;
      r_s_valid <= sreset;
      if (sreset) begin
        r_s_out   <= w_out;
        r_sat     <= r_sat_acc | (sen & w_acc_clamp) | w_out_clamp;
        r_acc     <= '0;
        r_sat_acc <= 1'b0;
      end else if (sen) begin
        r_acc <= w_acc_next;
        if (w_acc_clamp) r_sat_acc <= 1'b1;
      end
    end
  end

  assign sat_acc = r_sat_acc;
  assign sat     = r_sat;
  assign s_out   = r_s_out;
  assign s_valid = r_s_valid;

endmodule

// File: tb/tb_dsp_mac_q.sv
// Bench for dsp_mac_q: table of accumulate/drain vectors plus hand-written
// sequences for simultaneous sen/sreset, back-to-back drains and mid-run reset.
module tb_dsp_mac_q;

  logic        clk = 1'b0;
  logic        rst, aen, ben, men, sen, sreset, uns, rnd;
  logic [15:0] a_value, b_value;
  logic [4:0]  shift;
  logic        sat_acc, sat, s_valid;
  logic [15:0] s_out;

  dsp_mac_q dut (
    .clk(clk), .rst(rst), .a_value(a_value), .b_value(b_value),
    .aen(aen), .ben(ben), .men(men), .sen(sen), .sreset(sreset),
    .uns(uns), .shift(shift), .rnd(rnd),
    .sat_acc(sat_acc), .sat(sat), .s_out(s_out), .s_valid(s_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        uns;
    logic [15:0] a;
    logic [15:0] b;
    int          n;
    logic [4:0]  sh;
    logic        rnd;
    logic [15:0] exp_out;
    logic        exp_sat;
    logic        exp_sacc;
  } vec_t;

  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  int          ndrain = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mac(input logic [15:0] a, input logic [15:0] b);
    a_value = a; b_value = b; aen = 1'b1; ben = 1'b1;
    step();
    aen = 1'b0; ben = 1'b0; men = 1'b1;
    step();
    men = 1'b0; sen = 1'b1;
    step();
    sen = 1'b0;
  endtask

  task automatic drain(input logic [15:0] eo, input logic es);
    exp_q.push_back({es, eo});
    sreset = 1'b1;
    step();
    sreset = 1'b0;
  endtask

  // Scoreboard: every s_valid cycle must match the oldest pending drain.
  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL valid: unexpected s_valid, s_out=0x%04h", s_out);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        ndrain++;
        $display("drain %0d: s_out=0x%04h sat=%0b (want 0x%04h sat=%0b)",
                 ndrain, s_out, sat, e[15:0], e[16]);
        chk("s_out", {16'h0, s_out}, {16'h0, e[15:0]});
        chk("sat", {31'h0, sat}, {31'h0, e[16]});
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b0, 16'd3,    16'hFFFB, 4, 5'd0,  1'b0, 16'hFFC4, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h4000, 16'h4000, 1, 5'd0,  1'b0, 16'h7FFF, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'h4000, 16'h4000, 1, 5'd16, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h8000, 16'h8000, 2, 5'd16, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 16'd12,   16'h2000, 1, 5'd16, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'd12,   16'h2000, 1, 5'd16, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'hFFF4, 16'h2000, 1, 5'd16, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'hFFF4, 16'h2000, 1, 5'd16, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1, 5'd16, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1, 5'd0,  1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'hFFFF, 16'hFFFF, 0, 5'd0,  1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'hFFF9, 16'd9,    3, 5'd0,  1'b0, 16'hFF43, 1'b0, 1'b0};

    rst = 1'b1; aen = 1'b0; ben = 1'b0; men = 1'b0; sen = 1'b0; sreset = 1'b0;
    uns = 1'b0; rnd = 1'b0; shift = 5'd0; a_value = 16'h0; b_value = 16'h0;
    step();
    step();
    rst = 1'b0;
    chk("reset s_out", {16'h0, s_out}, 32'h0);
    chk("reset sat", {31'h0, sat}, 32'h0);
    chk("reset sat_acc", {31'h0, sat_acc}, 32'h0);
    chk("reset s_valid", {31'h0, s_valid}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      uns = vecs[i].uns; shift = vecs[i].sh; rnd = vecs[i].rnd;
      for (int k = 0; k < vecs[i].n; k++) mac(vecs[i].a, vecs[i].b);
      chk("sat_acc pre-drain", {31'h0, sat_acc}, {31'h0, vecs[i].exp_sacc});
      drain(vecs[i].exp_out, vecs[i].exp_sat);
      chk("sat_acc post-drain", {31'h0, sat_acc}, 32'h0);
    end

    // sen and sreset together (acc=10, prod=5), then a back-to-back empty drain.
    uns = 1'b0; shift = 5'd0; rnd = 1'b0;
    mac(16'd2, 16'd5);
    a_value = 16'd1; b_value = 16'd5; aen = 1'b1; ben = 1'b1;
    step();
    aen = 1'b0; ben = 1'b0; men = 1'b1;
    step();
    men = 1'b0; sen = 1'b1; sreset = 1'b1;
    exp_q.push_back({1'b0, 16'd15});
    step();
    sen = 1'b0;
    exp_q.push_back({1'b0, 16'd0});
    step();
    sreset = 1'b0;

    // Reset mid-accumulation overrides every enable, including a drain.
    mac(16'd3, 16'hFFFB);
    drain(16'hFFF1, 1'b0);
    mac(16'h8000, 16'h8000);
    mac(16'h8000, 16'h8000);
    chk("sat_acc before rst", {31'h0, sat_acc}, 32'h1);
    a_value = 16'h1234; b_value = 16'h0042;
    aen = 1'b1; ben = 1'b1; men = 1'b1; sen = 1'b1; sreset = 1'b1; rst = 1'b1;
    step();
    aen = 1'b0; ben = 1'b0; men = 1'b0; sen = 1'b0; sreset = 1'b0; rst = 1'b0;
    chk("rst s_out", {16'h0, s_out}, 32'h0);
    chk("rst sat", {31'h0, sat}, 32'h0);
    chk("rst sat_acc", {31'h0, sat_acc}, 32'h0);
    chk("rst s_valid", {31'h0, s_valid}, 32'h0);
    // Product register was cleared too, so accumulating it adds nothing.
    sen = 1'b1;
    step();
    sen = 1'b0;
    drain(16'h0000, 1'b0);

    step();
    step();
    step();
    chk("pending drains", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
